// File: rtl/systolic_array_os_pkg.sv
// Shared types and constants for the output-stationary systolic array.
package systolic_array_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 32;

  typedef logic signed [DATA_W_DEF-1:0] word_t;

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} sa_state_t;

  // Cycles needed after the last beat for it to reach PE(ROWS-1,COLS-1).
  function automatic int unsigned flush_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/systolic_array_os_if.sv
// Job control, operand stream and result stream of the systolic array.
interface systolic_array_os_if
  import systolic_array_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned K_MAX  = 64
) ();
  localparam int unsigned KW = $clog2(K_MAX + 1);

  logic                     start;
  logic [KW-1:0]            k_len;
  logic                     a_valid;
  logic                     a_ready;
  logic [ROWS*DATA_W-1:0]   a_data;
  logic [COLS*DATA_W-1:0]   b_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS*ACC_W-1:0]    out_data;
  logic                     out_last;
  logic                     busy;
  logic                     overflow;

  modport master (
    output start, k_len, a_valid, a_data, b_data, out_ready,
    input  a_ready, out_valid, out_data, out_last, busy, overflow
  );

  modport slave (
    input  start, k_len, a_valid, a_data, b_data, out_ready,
    output a_ready, out_valid, out_data, out_last, busy, overflow
  );
endinterface

// File: rtl/systolic_array_os_pe.sv
// Output-stationary PE: forwards a right and b down, accumulates a*b when both are valid.
module mac_pe_os #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic                     i_a_vld,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic                     i_b_vld,
  output logic signed [DATA_W-1:0] o_a,
  output logic                     o_a_vld,
  output logic signed [DATA_W-1:0] o_b,
  output logic                     o_b_vld,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic                     o_ovf
);
  logic signed [DATA_W-1:0]   r_a, r_b;
  logic                       r_a_vld, r_b_vld;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_ovf;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext, w_sum;
  logic                       w_add_ovf;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_a_vld <= 1'b0;
      r_b_vld <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (i_en) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_a_vld <= i_a_vld;
        r_b_vld <= i_b_vld;
      end
      if (i_clr) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else if (i_en && i_a_vld && i_b_vld) begin
        r_acc <= w_sum;
        if (w_add_ovf) r_ovf <= 1'b1;
      end
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_a_vld = r_a_vld;
  assign o_b_vld = r_b_vld;
  assign o_acc   = r_acc;
  assign o_ovf   = r_ovf;
endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS array computing C = A x B with runtime K and row-wise drain.
module systolic_array_os
  import systolic_array_pkg::*;
#(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned K_MAX  = 64
) (
  input logic                clk,
  input logic                rst,
  systolic_array_os_if.slave sa
);
  localparam int unsigned KW   = $clog2(K_MAX + 1);
  localparam int unsigned FLEN = flush_len(ROWS, COLS);
  localparam int unsigned FW   = (FLEN > 1) ? $clog2(FLEN) : 1;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (ACC_W < 2*DATA_W) begin : g_bad_acc_w
    $error("systolic_array_os: ACC_W must be at least 2*DATA_W");
  end

  sa_state_t           r_state;
  logic [KW-1:0]       r_k_len, r_beat, w_k_clamped;
  logic [FW-1:0]       r_flush;
  logic [RW-1:0]       r_row;
  logic                r_a_ready, r_busy, r_out_valid, r_out_last;
  logic                w_accept, w_en, w_clr, w_ovf_any;
  logic [COLS*ACC_W-1:0] w_row;

  logic [DATA_W-1:0] w_a_h [ROWS][COLS+1];
  logic              w_av  [ROWS][COLS+1];
  logic [DATA_W-1:0] w_b_v [ROWS+1][COLS];
  logic              w_bv  [ROWS+1][COLS];
  logic [ACC_W-1:0]  w_acc [ROWS][COLS];
  logic              w_ovf [ROWS][COLS];

  assign w_accept    = r_a_ready && sa.a_valid;
  assign w_en        = (r_state == COMPUTE) || (r_state == FLUSH);
  assign w_clr       = (r_state == IDLE) && sa.start;
  assign w_k_clamped = (sa.k_len > KW'(K_MAX)) ? KW'(K_MAX) : sa.k_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k_len     <= '0;
      r_beat      <= '0;
      r_flush     <= '0;
      r_row       <= '0;
      r_a_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (sa.start) begin
          r_busy <= 1'b1;
          r_beat <= '0;
          r_row  <= '0;
          if (sa.k_len == '0) begin
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_out_last  <= (ROWS == 1);
          end else begin
            r_state   <= COMPUTE;
            r_k_len   <= w_k_clamped;
            r_a_ready <= 1'b1;
          end
        end
        COMPUTE: if (w_accept) begin
          r_beat <= r_beat + KW'(1);
          if (r_beat + KW'(1) == r_k_len) begin
            r_state   <= FLUSH;
            r_a_ready <= 1'b0;
            r_flush   <= '0;
          end
        end
        FLUSH: begin
          if (r_flush == FW'(FLEN - 1)) begin
            r_state     <= DRAIN;
            r_out_valid <= 1'b1;
            r_out_last  <= (ROWS == 1);
            r_row       <= '0;
          end else begin
            r_flush <= r_flush + FW'(1);
          end
        end
        DRAIN: if (sa.out_ready) begin
          if (r_out_last) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_row       <= '0;
          end else begin
            r_row      <= r_row + RW'(1);
            r_out_last <= (r_row + RW'(1) == RW'(ROWS - 1));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Row i of A is delayed i cycles, column j of B j cycles; idle cycles inject zero bubbles.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    logic [DATA_W-1:0] w_inj;
    assign w_inj = w_accept ? sa.a_data[gi*DATA_W +: DATA_W] : '0;
    if (gi == 0) begin : g_direct
      assign w_a_h[gi][0] = w_inj;
      assign w_av[gi][0]  = w_accept;
    end else begin : g_chain
      logic [DATA_W-1:0] r_d [gi];
      logic [gi-1:0]     r_v;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned s = 0; s < gi; s++) r_d[s] <= '0;
          r_v <= '0;
        end else if (w_en) begin
          r_d[0] <= w_inj;
          r_v[0] <= w_accept;
          for (int unsigned s = 1; s < gi; s++) begin
            r_d[s] <= r_d[s-1];
            r_v[s] <= r_v[s-1];
          end
        end
      end
      assign w_a_h[gi][0] = r_d[gi-1];
      assign w_av[gi][0]  = r_v[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    logic [DATA_W-1:0] w_inj;
    assign w_inj = w_accept ? sa.b_data[gj*DATA_W +: DATA_W] : '0;
    if (gj == 0) begin : g_direct
      assign w_b_v[0][gj] = w_inj;
      assign w_bv[0][gj]  = w_accept;
    end else begin : g_chain
      logic [DATA_W-1:0] r_d [gj];
      logic [gj-1:0]     r_v;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned s = 0; s < gj; s++) r_d[s] <= '0;
          r_v <= '0;
        end else if (w_en) begin
          r_d[0] <= w_inj;
          r_v[0] <= w_accept;
          for (int unsigned s = 1; s < gj; s++) begin
            r_d[s] <= r_d[s-1];
            r_v[s] <= r_v[s-1];
          end
        end
      end
      assign w_b_v[0][gj] = r_d[gj-1];
      assign w_bv[0][gj]  = r_v[gj-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      mac_pe_os #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_en),
        .i_clr   (w_clr),
        .i_a     (w_a_h[gi][gj]),
        .i_a_vld (w_av[gi][gj]),
        .i_b     (w_b_v[gi][gj]),
        .i_b_vld (w_bv[gi][gj]),
        .o_a     (w_a_h[gi][gj+1]),
        .o_a_vld (w_av[gi][gj+1]),
        .o_b     (w_b_v[gi+1][gj]),
        .o_b_vld (w_bv[gi+1][gj]),
        .o_acc   (w_acc[gi][gj]),
        .o_ovf   (w_ovf[gi][gj])
      );
    end
  end

  always_comb begin
    w_ovf_any = 1'b0;
    w_row     = '0;
    for (int unsigned i = 0; i < ROWS; i++)
      for (int unsigned j = 0; j < COLS; j++)
        w_ovf_any = w_ovf_any | w_ovf[i][j];
    for (int unsigned j = 0; j < COLS; j++)
      w_row[j*ACC_W +: ACC_W] = w_acc[r_row][j];
  end

  assign sa.a_ready   = r_a_ready;
  assign sa.busy      = r_busy;
  assign sa.out_valid = r_out_valid;
  assign sa.out_last  = r_out_last;
  assign sa.out_data  = r_out_valid ? w_row : '0;
  assign sa.overflow  = w_ovf_any;
endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench: 32-bit and 16-bit accumulator arrays driven in lockstep.
module tb_systolic_array_os;
  import systolic_array_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, a_valid, out_ready;
  logic [6:0]  k_len;
  logic [31:0] a_data, b_data;

  systolic_array_os_if                  if32();
  systolic_array_os_if #(.ACC_W(16))    if16();

  assign if32.start = start;   assign if16.start = start;
  assign if32.k_len = k_len;   assign if16.k_len = k_len;
  assign if32.a_valid = a_valid; assign if16.a_valid = a_valid;
  assign if32.a_data = a_data; assign if16.a_data = a_data;
  assign if32.b_data = b_data; assign if16.b_data = b_data;
  assign if32.out_ready = out_ready; assign if16.out_ready = out_ready;

  systolic_array_os               u_dut32 (.clk(clk), .rst(rst), .sa(if32.slave));
  systolic_array_os #(.ACC_W(16)) u_dut16 (.clk(clk), .rst(rst), .sa(if16.slave));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int A [4][4];
  int B [4][4];
  int C32 [4][4];
  int C16 [4][4];
  bit ovf16;
  int k_cur;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // big=0: A = I4, B = 1..16 row-major; big=1: every element 127
  task automatic set_ops(input bit big);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        A[i][j] = big ? 127 : int'(i == j);
        B[i][j] = big ? 127 : i*4 + j + 1;
      end
  endtask

  task automatic model();
    int p, s, w, acc32, acc16;
    ovf16 = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc32 = 0;
        acc16 = 0;
        for (int k = 0; k < k_cur; k++) begin
          p = A[i][k] * B[k][j];
          acc32 += p;
          s = acc16 + p;
          w = int'(shortint'(s));
          if (((acc16 < 0) == (p < 0)) && ((w < 0) != (acc16 < 0))) ovf16 = 1'b1;
          acc16 = w;
        end
        C32[i][j] = acc32;
        C16[i][j] = acc16;
      end
  endtask

  task automatic load_col(input int k);
    for (int i = 0; i < 4; i++) begin
      a_data[i*8 +: 8] = 8'(A[i][k]);
      b_data[i*8 +: 8] = 8'(B[k][i]);
    end
  endtask

  task automatic check_row(input string tag, input int r);
    logic [127:0] e32;
    logic [63:0]  e16;
    for (int j = 0; j < 4; j++) begin
      e32[j*32 +: 32] = 32'(C32[r][j]);
      e16[j*16 +: 16] = 16'(C16[r][j]);
    end
    check({tag, "_d32"}, if32.out_data, e32);
    check({tag, "_d16"}, if16.out_data, {64'd0, e16});
    check({tag, "_last"}, if32.out_last, (r == 3));
  endtask

  task automatic drain(input int stall_row, input int stall_n);
    for (int r = 0; r < 4; r++) begin
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check_row("stall", r);
          check("stall_busy", if32.busy, 1);
          tick();
        end
      end
      out_ready = 1'b1;
      check("row_valid", if32.out_valid, 1);
      check("row_busy", if16.busy, 1);
      check_row("row", r);
      tick();
    end
    out_ready = 1'b0;
    check("end_valid", if32.out_valid, 0);
    check("end_busy", if32.busy, 0);
    check("end_last", if16.out_last, 0);
    check("ovf32", if32.overflow, 0);
    check("ovf16", if16.overflow, ovf16);
  endtask

  task automatic run_job(input int k, input bit bubbles, input bit poke, input int stall_row, input int stall_n);
    int beat, guard, lat;
    bit ph, acc;
    k_cur = k;
    model();
    start = 1'b1;
    k_len = 7'(k);
    tick();
    start = 1'b0;
    check("start_busy", if32.busy, 1);
    check("start_ready", if16.a_ready, 1);
    beat = 0;
    guard = 0;
    ph = 1'b1;
    while (beat < k && guard < 100) begin
      a_valid = bubbles ? ph : 1'b1;
      ph = !ph;
      load_col(beat);
      if (poke && beat == 1) begin
        start = 1'b1;
        k_len = 7'd0;
      end
      acc = a_valid && if32.a_ready;
      tick();
      guard++;
      start = 1'b0;
      if (acc) beat++;
    end
    a_valid = 1'b0;
    check("beats", beat, k);
    lat = 1;
    while (!if32.out_valid && lat < 40) begin
      check("flush_ready", if32.a_ready, 0);
      tick();
      lat++;
    end
    check("latency", lat, 8);
    drain(stall_row, stall_n);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; k_len = '0; a_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
    #12;
    check("rst_busy", if32.busy, 0);
    check("rst_ready", if32.a_ready, 0);
    check("rst_valid", if16.out_valid, 0);
    check("rst_last", if32.out_last, 0);
    check("rst_ovf", if16.overflow, 0);
    check("rst_data", if32.out_data, 0);
    rst = 1'b0;
    tick();
    tick();

    set_ops(1'b0);
    run_job(4, 1'b0, 1'b0, -1, 0);   // identity
    run_job(4, 1'b1, 1'b0, -1, 0);   // bubbles
    run_job(4, 1'b0, 1'b0, 1, 5);    // backpressure on row 1

    set_ops(1'b1);
    run_job(4, 1'b0, 1'b0, -1, 0);   // 16-bit wraps to 0xFC04 and flags overflow
    set_ops(1'b0);
    run_job(4, 1'b0, 1'b0, -1, 0);   // next job clears overflow

    start = 1'b1; k_len = 7'd4;
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      a_valid = 1'b1;
      load_col(b);
      tick();
    end
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", if32.busy, 0);
    check("mid_rst_ready", if32.a_ready, 0);
    check("mid_rst_valid", if16.out_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    run_job(4, 1'b0, 1'b0, -1, 0);   // full job after reset

    run_job(4, 1'b0, 1'b1, -1, 0);   // start pulsed during COMPUTE

    k_cur = 0;
    model();
    start = 1'b1; k_len = 7'd0;
    tick();
    start = 1'b0;
    check("k0_valid", if32.out_valid, 1);
    check("k0_ready", if32.a_ready, 0);
    drain(-1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
